// File: rtl/mem_stream_reader.sv
// Read-side sequencer for the synchronous-read data memory: walks a contiguous
// address range and presents the words as a valid/ready byte stream with last marking.
module mem_stream_reader #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_ADDR = 2499
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_read_select,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                   state, state_nx;
  logic [ADDR_W-1:0]        base_q, len_q, issued, popped;
  logic                     skip_q, err_q;
  logic                     inflight;  // address presented this cycle, data due next cycle
  logic                     rd_pend;   // mem_read_data holds a word not yet captured
  logic [1:0][DATA_W-1:0]   fifo;
  logic                     head;
  logic [1:0]               cnt;

  logic [ADDR_W:0]          end_addr;
  logic                     zero_len, range_bad, start_ok;
  logic                     pop, issue, capture;
  logic [2:0]               occ_nx;

  assign end_addr  = {1'b0, base_addr} + {1'b0, length} - (ADDR_W+1)'(1);
  assign zero_len  = (length == '0);
  assign range_bad = (end_addr > (ADDR_W+1)'(MAX_ADDR));
  assign start_ok  = (state == IDLE) && start;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign occ_nx    = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && !skip_q && (issued != len_q) && (occ_nx < 3'd2);

  // A pending word whose capture is blocked by a full buffer stays readable on
  // mem_read_data: the issue rule guarantees the address is not advanced meanwhile.
  assign capture   = rd_pend && ((cnt != 2'd2) || pop);

  assign out_data  = out_valid ? fifo[head] : '0;
  assign out_last  = out_valid && (popped == len_q - ADDR_W'(1));

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN: begin
        if (skip_q)               state_nx = FIN;
        else if (issued == len_q) state_nx = DRAIN;
      end
      DRAIN: if (!inflight && !rd_pend && ((cnt == 2'd0) || ((cnt == 2'd1) && pop)))
               state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q          <= '0;
      len_q           <= '0;
      issued          <= '0;
      popped          <= '0;
      skip_q          <= 1'b0;
      err_q           <= 1'b0;
      inflight        <= 1'b0;
      rd_pend         <= 1'b0;
      mem_read_select <= '0;
      fifo            <= '0;
      head            <= 1'b0;
      cnt             <= 2'd0;
    end else begin
      if (start_ok) begin
        base_q <= base_addr;
        len_q  <= length;
        popped <= '0;
        skip_q <= zero_len || range_bad;
        err_q  <= !zero_len && range_bad;
        // The first read goes out with the accepted start so data lands in cycle 2.
        if (!zero_len && !range_bad) begin
          mem_read_select <= base_addr;
          inflight        <= 1'b1;
          issued          <= ADDR_W'(1);
        end else begin
          inflight <= 1'b0;
          issued   <= '0;
        end
      end else begin
        inflight <= issue;
        if (issue) begin
          mem_read_select <= base_q + issued;
          issued          <= issued + ADDR_W'(1);
        end
      end

      rd_pend <= inflight || (rd_pend && !capture);
      if (capture) fifo[head ^ cnt[0]] <= mem_read_data;
      if (pop) begin
        head   <= ~head;
        popped <= popped + ADDR_W'(1);
      end
      cnt <= cnt + {1'b0, capture} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory model, word-queue scoreboard, directed and random commands.
module tb_mem_stream_reader;
  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXA = 2499;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0, length = '0;
  logic          busy, done, err, out_valid, out_last;
  logic [AW-1:0] mem_read_select;
  logic [DW-1:0] mem_read_data = '0, out_data;

  logic [7:0] mem [0:MAXA];
  logic [5:0] pat = 6'b101001;
  int   tests = 0, fails = 0, cyc = 0, t0 = 0, rdy_mode = 0, acc_cnt = 0, cmd_base = 0;
  bit   cmd_legal = 1'b0;
  logic [8:0] exp_q[$];
  int   log_k[$], log_d[$], log_l[$];
  bit   prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [8:0] mon_e;

  mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .mem_read_select(mem_read_select),
    .mem_read_data(mem_read_data), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    mem_read_data <= (int'(mem_read_select) <= MAXA) ? mem[mem_read_select] : 8'h00;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[cyc % 6];
      default: out_ready = ($urandom_range(0, 9) < 6);
    endcase
  end

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Stream scoreboard: each accepted word must be the next expected one.
  always @(negedge clk) begin
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (busy && cmd_legal)
        chk("select_window", int'((int'(mem_read_select) - cmd_base) <= acc_cnt + 2), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("stream_data", out_data, mon_e[7:0]);
          chk("stream_last", out_last, mon_e[8]);
        end
        log_k.push_back(cyc - t0);
        log_d.push_back(out_data);
        log_l.push_back(out_last);
        acc_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_select"}, mem_read_select, 0);
  endtask

  task automatic launch(input int b, input int l);
    start = 1'b1;
    base_addr = AW'(b);
    length = AW'(l);
    t0 = cyc;
    cmd_base = b;
    acc_cnt = 0;
    cmd_legal = (l != 0) && (b + l - 1 <= MAXA);
    log_k.delete(); log_d.delete(); log_l.delete();
    if (cmd_legal)
      for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), mem[b + i]});
  endtask

  task automatic run_cmd(input int b, input int l, input bit hold);
    int k;
    bit seen;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    launch(b, l);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_c1", busy, 1);
    if (cmd_legal) chk("select_c1", mem_read_select, b);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 400) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      chk("err_flag", err, int'(l != 0 && !cmd_legal));
      chk("busy_at_done", busy, 0);
      if (!cmd_legal)         chk("done_cycle", k, 2);
      else if (rdy_mode == 0) chk("done_cycle", k, l + 3);
    end
    chk("words_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    for (int a = 0; a <= MAXA; a++) mem[a] = a[7:0];
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    rdy_mode = 0;
    run_cmd(10, 4, 1'b0);
    chk("t1_count", log_k.size(), 4);
    for (int i = 0; i < 4 && i < log_k.size(); i++) begin
      chk("t1_cycle", log_k[i], 3 + i);
      chk("t1_data", log_d[i], 10 + i);
      chk("t1_last", log_l[i], int'(i == 3));
    end

    rdy_mode = 1;
    run_cmd(100, 8, 1'b0);
    chk("toggle_count", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) chk("toggle_data", log_d[i], 100 + i);

    rdy_mode = 0;
    run_cmd(2496, 4, 1'b0);
    chk("top_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("top_first", log_d[0], 192);
      chk("top_final", log_d[3], 195);
    end
    run_cmd(2497, 4, 1'b0);
    chk("illegal_words", log_d.size(), 0);
    run_cmd(5, 0, 1'b0);
    chk("zero_words", log_d.size(), 0);

    // Abort mid-command.
    @(negedge clk);
    launch(200, 20);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (acc_cnt < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_3", int'(acc_cnt >= 3), 1);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    cmd_legal = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    run_cmd(0, 2, 1'b0);
    chk("after_abort_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("after_abort_d0", log_d[0], 0);
      chk("after_abort_d1", log_d[1], 1);
    end

    // Start held through a whole command, then accepted again right after done.
    run_cmd(50, 3, 1'b1);
    run_cmd(50, 3, 1'b0);
    chk("hold_second_count", log_d.size(), 3);

    for (int a = 0; a <= MAXA; a++) mem[a] = 8'($urandom);
    for (int it = 0; it < 30; it++) begin
      int b, l;
      rdy_mode = (it % 3 == 0) ? 0 : 2;
      b = (it % 4 == 0) ? $urandom_range(2470, MAXA) : $urandom_range(0, MAXA);
      l = (it % 5 == 0) ? $urandom_range(25, 60) : $urandom_range(0, 24);
      run_cmd(b, l, 1'b0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
